matrix_odoter: RTL and testbench

- Element-wise (Hadamard) multiplier for two H×W signed fixed-point matrices.
- Matrices are passed as flat packed buses. Each output element y[r][c] = a[r][c] × b[r][c], rescaled to the input fixed-point format and saturated.
- Pipelined, two-cycle datapath with a valid strobe. Used as the element-wise gating/scaling stage in the CRNN datapath.

---
 rtl/matrix_odoter.sv | 84 ++++++++
 tb/tb_matrix_odoter.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/matrix_odoter.sv
// Element-wise (Hadamard) product of two HxW signed fixed-point matrices.
// Two-stage pipeline: full-precision multiply, then rescale with floor truncation and saturation.
module matrix_odoter #(
    parameter int H           = 4,
    parameter int W           = 3,
    parameter int DATA_WIDTH  = 16,
    parameter int FRACT_WIDTH = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_valid,
    input  logic [H*W*DATA_WIDTH-1:0]    a,
    input  logic [H*W*DATA_WIDTH-1:0]    b,
    output logic [H*W*DATA_WIDTH-1:0]    y,
    output logic                         out_valid,
    output logic [H*W-1:0]               sat
);

    localparam int N  = H * W;
    localparam int PW = 2 * DATA_WIDTH;

    localparam logic signed [PW-1:0] MAX_Q =
        {{(PW-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
    localparam logic signed [PW-1:0] MIN_Q =
        {{(PW-DATA_WIDTH+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}};

    // Returns {sat_flag, element}; shift floors toward -inf, no rounding.
    function automatic logic [DATA_WIDTH:0] rescale_sat(input logic signed [PW-1:0] p);
        logic signed [PW-1:0] q;
        logic [DATA_WIDTH:0]  r;
        q = p >>> FRACT_WIDTH;
        if (q > MAX_Q)
            r = {1'b1, 1'b0, {(DATA_WIDTH-1){1'b1}}};
        else if (q < MIN_Q)
            r = {1'b1, 1'b1, {(DATA_WIDTH-1){1'b0}}};
        else
            r = {1'b0, q[DATA_WIDTH-1:0]};
        return r;
    endfunction

    logic signed [PW-1:0]   prod_p1 [N];
    logic                   vld_p1;
    logic [N*DATA_WIDTH-1:0] y_d;
    logic [N-1:0]           sat_d;

    // Stage 1: exact signed products, held while no new input arrives
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_p1 <= 1'b0;
            for (int i = 0; i < N; i++)
                prod_p1[i] <= '0;
        end else begin
            vld_p1 <= in_valid;
            if (in_valid) begin
                for (int i = 0; i < N; i++)
                    prod_p1[i] <= PW'($signed(a[i*DATA_WIDTH +: DATA_WIDTH]))
                                * PW'($signed(b[i*DATA_WIDTH +: DATA_WIDTH]));
            end
        end
    end

    always_comb begin
        y_d   = '0;
        sat_d = '0;
        for (int i = 0; i < N; i++)
            {sat_d[i], y_d[i*DATA_WIDTH +: DATA_WIDTH]} = rescale_sat(prod_p1[i]);
    end

    // Stage 2: rescaled, saturated result registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            y         <= '0;
            sat       <= '0;
        end else begin
            out_valid <= vld_p1;
            if (vld_p1) begin
                y   <= y_d;
                sat <= sat_d;
            end
        end
    end

endmodule

// File: tb/tb_matrix_odoter.sv
// Scoreboard bench for matrix_odoter: expected results queued at drive time, checked at output.
module tb_matrix_odoter;

    localparam int H  = 4;
    localparam int W  = 3;
    localparam int DW = 16;
    localparam int FW = 8;
    localparam int N  = H * W;
    localparam int NB = N * DW;

    typedef struct {
        logic [NB-1:0] y;
        logic [N-1:0]  s;
        int            cyc;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic [NB-1:0] a = '0;
    logic [NB-1:0] b = '0;
    logic [NB-1:0] y;
    logic          out_valid;
    logic [N-1:0]  sat;

    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;
    int   got_cnt  = 0;
    exp_t sb[$];

    matrix_odoter #(.H(H), .W(W), .DATA_WIDTH(DW), .FRACT_WIDTH(FW)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .a(a), .b(b),
        .y(y), .out_valid(out_valid), .sat(sat)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic void model(input logic [NB-1:0] av, input logic [NB-1:0] bv,
                                  output logic [NB-1:0] ye, output logic [N-1:0] se);
        longint p, q;
        longint maxv, minv;
        maxv = (longint'(1) << (DW-1)) - 1;
        minv = -(longint'(1) << (DW-1));
        ye = '0;
        se = '0;
        for (int i = 0; i < N; i++) begin
            p = longint'($signed(av[i*DW +: DW])) * longint'($signed(bv[i*DW +: DW]));
            q = p >>> FW;
            if (q > maxv) begin
                ye[i*DW +: DW] = DW'(maxv);
                se[i] = 1'b1;
            end else if (q < minv) begin
                ye[i*DW +: DW] = DW'(minv);
                se[i] = 1'b1;
            end else begin
                ye[i*DW +: DW] = DW'(q);
            end
        end
    endfunction

    // Called at posedge+1; DUT captures at the next edge, result visible two edges later.
    task automatic drive(input logic [NB-1:0] av, input logic [NB-1:0] bv);
        exp_t e;
        model(av, bv, e.y, e.s);
        e.cyc = cyc + 2;
        sb.push_back(e);
        a = av;
        b = bv;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    always @(negedge clk) begin
        if (!rst && out_valid) begin
            got_cnt++;
            if (sb.size() == 0) begin
                check("unexpected_out_valid", 256'(out_valid), 256'(0));
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("latency", 256'(cyc), 256'(e.cyc));
                check("y", 256'(y), 256'(e.y));
                check("sat", 256'(sat), 256'(e.s));
            end
        end
    end

    initial begin
        logic [NB-1:0] av, bv, ye_hold;
        logic [N-1:0]  se_hold;
        int            waited;

        #1;
        check("reset_y", 256'(y), 256'(0));
        check("reset_out_valid", 256'(out_valid), 256'(0));
        check("reset_sat", 256'(sat), 256'(0));
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;

        // 0.25 * 0.25
        for (int i = 0; i < N; i++) begin
            av[i*DW +: DW] = DW'(64);
            bv[i*DW +: DW] = DW'(64);
        end
        model(av, bv, ye_hold, se_hold);
        drive(av, bv);
        idle(4);
        check("hold_out_valid", 256'(out_valid), 256'(0));
        check("hold_y", 256'(y), 256'(ye_hold));
        check("hold_y_raw16", 256'(y[DW-1:0]), 256'(16));

        // alternating signs, mixed magnitudes
        for (int i = 0; i < N; i++) begin
            av[i*DW +: DW] = (i % 2 == 0) ? DW'(192) : DW'(-64);
            bv[i*DW +: DW] = (i % 3 == 0) ? DW'(4096) : DW'(-1024);
        end
        drive(av, bv);
        idle(3);

        for (int i = 0; i < N; i++) begin
            av[i*DW +: DW] = (i < 6) ? DW'(-1024) : DW'(2048);
            bv[i*DW +: DW] = (i < 4) ? DW'(3072) : DW'(-2048);
        end
        drive(av, bv);
        idle(3);

        // zero operand, then floor truncation of a tiny negative
        for (int i = 0; i < N; i++) begin
            av[i*DW +: DW] = DW'(2);
            bv[i*DW +: DW] = '0;
        end
        drive(av, bv);
        idle(3);
        for (int i = 0; i < N; i++) begin
            av[i*DW +: DW] = DW'(-1);
            bv[i*DW +: DW] = DW'(1);
        end
        drive(av, bv);
        idle(3);
        check("floor_trunc_raw", 256'(y[DW-1:0]), 256'(16'hFFFF));

        // saturation corners
        for (int i = 0; i < N; i++) begin
            av[i*DW +: DW] = 16'h7FFF;
            bv[i*DW +: DW] = 16'h7FFF;
        end
        drive(av, bv);
        idle(3);
        for (int i = 0; i < N; i++) bv[i*DW +: DW] = 16'h8000;
        drive(av, bv);
        idle(3);
        for (int i = 0; i < N; i++) av[i*DW +: DW] = 16'h8000;
        drive(av, bv);
        idle(3);

        // back-to-back stream with random data
        for (int k = 0; k < 3; k++) begin
            for (int i = 0; i < N; i++) begin
                av[i*DW +: DW] = DW'($urandom);
                bv[i*DW +: DW] = DW'($urandom);
            end
            drive(av, bv);
        end
        idle(4);

        // reset mid-stream discards in-flight data
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < N; i++) begin
                av[i*DW +: DW] = DW'($urandom_range(100, 3000));
                bv[i*DW +: DW] = DW'($urandom_range(100, 3000));
            end
            drive(av, bv);
        end
        rst = 1'b1;
        in_valid = 1'b0;
        #1;
        check("midrst_y", 256'(y), 256'(0));
        check("midrst_out_valid", 256'(out_valid), 256'(0));
        check("midrst_sat", 256'(sat), 256'(0));
        sb.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        idle(4);

        for (int i = 0; i < N; i++) begin
            av[i*DW +: DW] = DW'(i * 100 - 500);
            bv[i*DW +: DW] = DW'(300 - i * 50);
        end
        drive(av, bv);
        idle(1);

        waited = 0;
        while (sb.size() != 0 && waited < 20) begin
            @(posedge clk);
            #1;
            waited++;
        end
        check("drain", 256'(sb.size()), 256'(0));
        check("outputs_seen", 256'(got_cnt), 256'(12));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
